// File: rtl/frame_transmit_pkg.sv
// Shared constants, FSM encoding and sizing helper for the frame transmitter.
package frame_transmit_pkg;

    localparam logic [7:0] HEADER = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of whole bytes needed to carry a field of the given bit width.
    function automatic int unsigned num_bytes(input int unsigned bits);
        return (bits + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/frame_transmit_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// A new start is taken while idle or in the final stop-bit cycle, so
// consecutive bytes leave no idle time on the line.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       shreg;
    logic             tx_q;
    logic             at_bit_end;

    assign at_bit_end = active && (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign done       = at_bit_end && (bit_idx == 4'd9);
    assign tx         = tx_q;

    // Bit timing and shifting; start has priority over the stop-bit finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            tx_q    <= 1'b1;
        end else if (start && (!active || done)) begin
            active  <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= {1'b1, byte_in};
            tx_q    <= 1'b0;
        end else if (at_bit_end) begin
            cnt <= '0;
            if (bit_idx == 4'd9) begin
                active <= 1'b0;
                tx_q   <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                tx_q    <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else if (active) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_transmit.sv
// Frame transmitter: header, address bytes, data bytes and optional XOR
// checksum sent as back-to-back UART bytes.
module frame_transmit
    import frame_transmit_pkg::*;
#(
    parameter int DATA_W       = 25,
    parameter int ADDR_W       = 12,
    parameter int CLKS_PER_BIT = 868,
    parameter int CHK_EN       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned NA     = num_bytes(ADDR_W);
    localparam int unsigned ND     = num_bytes(DATA_W);
    localparam int unsigned TOTAL  = 1 + NA + ND + ((CHK_EN != 0) ? 1 : 0);
    localparam int unsigned LAST   = TOTAL - 1;
    localparam int unsigned AW_PAD = NA * 8;
    localparam int unsigned DW_PAD = ND * 8;
    localparam int unsigned IDX_W  = $clog2(TOTAL);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx;
    logic [AW_PAD-1:0] addr_q;
    logic [DW_PAD-1:0] data_q;
    logic [7:0]        nxt_byte;
    logic [7:0]        sel_byte;
    logic [7:0]        chk;
    logic [7:0]        ser_byte;
    logic              rdy_q;
    logic              accept;
    logic              ser_start;
    logic              ser_done;
    int unsigned       nxt;

    assign data_ready = rdy_q && (state == IDLE);
    assign accept     = data_ready && data_valid;
    // The header needs no captured data, so it is handed to the serializer
    // in the accepting cycle; later bytes are staged in LOAD.
    assign ser_byte   = (state == IDLE) ? HEADER : nxt_byte;

    // Pick the byte following the one on the line, and the running checksum.
    always_comb begin
        chk      = '0;
        sel_byte = '0;
        for (int unsigned i = 0; i < NA; i++) chk = chk ^ addr_q[8*i +: 8];
        for (int unsigned i = 0; i < ND; i++) chk = chk ^ data_q[8*i +: 8];
        nxt = 32'(idx) + 32'd1;
        if (nxt <= NA)
            sel_byte = addr_q[8*(NA-nxt) +: 8];
        else if (nxt <= NA + ND)
            sel_byte = data_q[8*(NA+ND-nxt) +: 8];
        else if (CHK_EN != 0)
            sel_byte = chk;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and control outputs.
    always_comb begin
        state_nx   = state;
        ser_start  = 1'b0;
        frame_done = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: if (accept) begin
                ser_start = 1'b1;
                state_nx  = LOAD;
            end
            LOAD: state_nx = SEND;
            SEND: if (ser_done) begin
                if (idx != IDX_W'(LAST)) begin
                    ser_start = 1'b1;
                    state_nx  = LOAD;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture, byte index and staging register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            idx      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            nxt_byte <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (accept) begin
                addr_q <= AW_PAD'(addr);
                data_q <= DW_PAD'(data);
                idx    <= '0;
            end else if (state == SEND && ser_done && idx != IDX_W'(LAST)) begin
                idx <= idx + IDX_W'(1);
            end
            if (state == LOAD) nxt_byte <= sel_byte;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (ser_start),
        .byte_in(ser_byte),
        .tx     (tx),
        .done   (ser_done)
    );

endmodule

// File: tb/tb_frame_transmit.sv
// Self-checking bench for frame_transmit: three configurations, UART line
// decoded at mid-bit against a byte-list model built from the frame rules.
module tb_frame_transmit;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  valid_v = '0;
    logic [24:0] data0 = '0, data1 = '0;
    logic [11:0] addr0 = '0, addr1 = '0;
    logic [7:0]  data2 = '0;
    logic [3:0]  addr2 = '0;
    logic        ready0, ready1, ready2, tx0, tx1, tx2;
    logic        busy0, busy1, busy2, done0, done1, done2;
    wire  [2:0]  ready_v = {ready2, ready1, ready0};
    wire  [2:0]  tx_v    = {tx2, tx1, tx0};
    wire  [2:0]  busy_v  = {busy2, busy1, busy0};
    wire  [2:0]  done_v  = {done2, done1, done0};

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    bit hold_valid = 1'b0;
    bit hold_new = 1'b0;
    logic [31:0] hold_a = '0, hold_d = '0;

    frame_transmit #(.DATA_W(25), .ADDR_W(12), .CLKS_PER_BIT(CPB), .CHK_EN(1)) u0 (
        .clk(clk), .rst_n(rst_n), .data_valid(valid_v[0]), .data_ready(ready0),
        .data(data0), .addr(addr0), .tx(tx0), .busy(busy0), .frame_done(done0));
    frame_transmit #(.DATA_W(25), .ADDR_W(12), .CLKS_PER_BIT(CPB), .CHK_EN(0)) u1 (
        .clk(clk), .rst_n(rst_n), .data_valid(valid_v[1]), .data_ready(ready1),
        .data(data1), .addr(addr1), .tx(tx1), .busy(busy1), .frame_done(done1));
    frame_transmit #(.DATA_W(8), .ADDR_W(4), .CLKS_PER_BIT(CPB), .CHK_EN(1)) u2 (
        .clk(clk), .rst_n(rst_n), .data_valid(valid_v[2]), .data_ready(ready2),
        .data(data2), .addr(addr2), .tx(tx2), .busy(busy2), .frame_done(done2));

    task automatic wait_cyc(input int unsigned t);
        if (cyc > t) begin
            checks++; errors++;
            $display("FAIL schedule: cycle %0d already past required %0d", cyc, t);
        end
        while (cyc < t) @(negedge clk);
    endtask

    task automatic set_inputs(input int inst, input logic [31:0] a, input logic [31:0] d);
        case (inst)
            0: begin addr0 = a[11:0]; data0 = d[24:0]; end
            1: begin addr1 = a[11:0]; data1 = d[24:0]; end
            default: begin addr2 = a[3:0]; data2 = d[7:0]; end
        endcase
    endtask

    // Reference frame: header, addr bytes MSB first, data bytes MSB first, XOR.
    task automatic build_exp(input int inst, input logic [31:0] a, input logic [31:0] d);
        int aw, dw;
        bit ck;
        logic [7:0] x, b;
        logic [31:0] am, dm;
        aw = (inst == 2) ? 4 : 12;
        dw = (inst == 2) ? 8 : 25;
        ck = (inst != 1);
        am = a & ((32'h1 << aw) - 32'h1);
        dm = d & ((32'h1 << dw) - 32'h1);
        x = '0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = (aw + 7) / 8 - 1; i >= 0; i--) begin
            b = 8'(am >> (8 * i)); exp_q.push_back(b); x = x ^ b;
        end
        for (int i = (dw + 7) / 8 - 1; i >= 0; i--) begin
            b = 8'(dm >> (8 * i)); exp_q.push_back(b); x = x ^ b;
        end
        if (ck) exp_q.push_back(x);
    endtask

    // Decode a frame accepted at edge acc and check timing of frame_done.
    task automatic rx_check(input int inst, input int unsigned acc);
        int unsigned n, len;
        logic [9:0] bits;
        n = exp_q.size();
        len = n * 10 * CPB;
        wait_cyc(acc);
        checks++;
        if (busy_v[inst] !== 1'b1 || ready_v[inst] !== 1'b0) begin
            errors++;
            $display("FAIL accept u%0d: busy=%b ready=%b, required busy=1 ready=0",
                     inst, busy_v[inst], ready_v[inst]);
        end
        valid_v[inst] = hold_valid;
        if (hold_new) set_inputs(inst, hold_a, hold_d);
        for (int unsigned k = 0; k < n; k++) begin
            for (int unsigned b = 0; b < 10; b++) begin
                wait_cyc(acc + k * 10 * CPB + b * CPB + 1);
                bits[b] = tx_v[inst];
            end
            checks++;
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[8:1] !== exp_q[k]) begin
                errors++;
                $display("FAIL byte u%0d[%0d]: start=%b data=%h stop=%b, required 0 %h 1",
                         inst, k, bits[0], bits[8:1], bits[9], exp_q[k]);
            end
        end
        wait_cyc(acc + len - 1);
        checks++;
        if (done_v[inst] !== 1'b0 || tx_v[inst] !== 1'b1) begin
            errors++;
            $display("FAIL early_done u%0d: frame_done=%b tx=%b, required 0 1",
                     inst, done_v[inst], tx_v[inst]);
        end
        wait_cyc(acc + len);
        checks++;
        if (done_v[inst] !== 1'b1 || busy_v[inst] !== 1'b1 || tx_v[inst] !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse u%0d @%0d: frame_done=%b busy=%b tx=%b, required 1 1 1",
                     inst, len, done_v[inst], busy_v[inst], tx_v[inst]);
        end
        wait_cyc(acc + len + 1);
        checks++;
        if (done_v[inst] !== 1'b0 || busy_v[inst] !== 1'b0 || ready_v[inst] !== 1'b1) begin
            errors++;
            $display("FAIL after_done u%0d: frame_done=%b busy=%b ready=%b, required 0 0 1",
                     inst, done_v[inst], busy_v[inst], ready_v[inst]);
        end
    endtask

    task automatic run_frame(input int inst, input logic [31:0] a, input logic [31:0] d);
        int unsigned acc;
        build_exp(inst, a, d);
        set_inputs(inst, a, d);
        valid_v[inst] = 1'b1;
        checks++;
        if (ready_v[inst] !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle u%0d: ready=%b, required 1", inst, ready_v[inst]);
        end
        acc = cyc + 1;
        rx_check(inst, acc);
        hold_valid = 1'b0;
        hold_new = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (tx_v !== 3'b111 || busy_v !== 3'b000 || ready_v !== 3'b000 || done_v !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b ready=%b done=%b, required 111 000 000 000",
                     tx_v, busy_v, ready_v, done_v);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready_v !== 3'b000) begin
            errors++;
            $display("FAIL ready_before_edge: ready=%b, required 000", ready_v);
        end
        @(negedge clk);
        checks++;
        if (ready_v !== 3'b111 || busy_v !== 3'b000 || tx_v !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_edge: ready=%b busy=%b tx=%b, required 111 000 111",
                     ready_v, busy_v, tx_v);
        end
    endtask

    task automatic test_directed();
        run_frame(0, 32'd255, 32'd1200);
        run_frame(1, 32'd255, 32'd1200);
        run_frame(2, 32'hF, 32'h81);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) run_frame(0, $urandom, $urandom);
        for (int i = 0; i < 2; i++) run_frame(1, $urandom, $urandom);
        for (int i = 0; i < 3; i++) run_frame(2, $urandom, $urandom);
        run_frame(0, 32'hFFF, 32'h1FFFFFF);
        run_frame(0, 32'h0, 32'h0);
    endtask

    task automatic test_hold_data();
        hold_new = 1'b1;
        hold_a = 32'hFFF;
        hold_d = 32'h1FFFFFF;
        run_frame(0, 32'd255, 32'd1200);
    endtask

    task automatic test_back_to_back();
        int unsigned acc;
        logic [31:0] a[3], d[3];
        for (int i = 0; i < 3; i++) begin
            a[i] = $urandom;
            d[i] = $urandom;
        end
        set_inputs(0, a[0], d[0]);
        valid_v[0] = 1'b1;
        acc = cyc + 1;
        for (int f = 0; f < 3; f++) begin
            build_exp(0, a[f], d[f]);
            hold_valid = (f < 2);
            hold_new = (f < 2);
            if (f < 2) begin
                hold_a = a[f+1];
                hold_d = d[f+1];
            end
            rx_check(0, acc);
            acc = acc + exp_q.size() * 10 * CPB + 2;
        end
        hold_valid = 1'b0;
        hold_new = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tail: ready=%b busy=%b tx=%b, required 1 0 1",
                     ready_v[0], busy_v[0], tx_v[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int unsigned acc;
        set_inputs(0, $urandom, $urandom);
        valid_v[0] = 1'b1;
        acc = cyc + 1;
        wait_cyc(acc);
        valid_v[0] = 1'b0;
        wait_cyc(acc + 4 * 10 * CPB + 5 * CPB);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_v !== 3'b111 || busy_v !== 3'b000 || ready_v !== 3'b000 || done_v !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset: tx=%b busy=%b ready=%b done=%b, required 111 000 000 000",
                     tx_v, busy_v, ready_v, done_v);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: tx=%b busy=%b, required 1 0", tx_v[0], busy_v[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_v[0] !== 1'b1 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: ready=%b tx=%b busy=%b, required 1 1 0",
                     ready_v[0], tx_v[0], busy_v[0]);
        end
        run_frame(0, $urandom, $urandom);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold_data();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
